alu_uart_if: RTL and testbench

- Interface stage between the UART receiver/transmitter and the ALU. It replaces the switch/button operand loading with a serial command frame.
- Collects three received bytes in fixed order: operand A, operand B, opcode. It drives the ALU inputs, captures the combinational ALU result, and hands it to the UART transmitter with a start/done handshake.
- A silence timeout abandons partial frames.

---
 rtl/alu_defs.sv | 31 +++
 rtl/alu_uart_timeout.sv | 38 +++
 rtl/alu_uart_if.sv | 111 +++++++++++
 tb/tb_alu_uart_if.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared constants for the UART-driven ALU command interface.
package alu_defs;

    localparam int NB_UART_DATA = 8;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_CALC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        CALC    = ST_CALC,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_e;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/alu_uart_timeout.sv
// Inter-byte silence counter; pulses o_expired on the last allowed idle cycle.
module alu_uart_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_expired = i_enable & ~i_clear & (cnt_q == LAST);

    // Restart from zero on expiry so the counter never wraps past LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_expired) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_if.sv
// Serial command front-end for the ALU: collects A, B, opcode bytes,
// latches the ALU result and hands it to the UART transmitter.
module alu_uart_if
    import alu_defs::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB_UART_DATA-1:0] i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_done,
    input  logic [NB_DATA-1:0]      i_alu_result,
    output logic [NB_DATA-1:0]      o_alu_data_A,
    output logic [NB_DATA-1:0]      o_alu_data_B,
    output logic [NB_OP-1:0]        o_alu_op,
    output logic [NB_UART_DATA-1:0] o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy
);

    state_e                  state_q;
    logic [NB_DATA-1:0]      a_q;
    logic [NB_DATA-1:0]      b_q;
    logic [NB_OP-1:0]        op_q;
    logic [NB_UART_DATA-1:0] tx_data_q;
    logic                    tx_start_q;
    logic                    busy_q;

    logic in_frame;
    logic expired;

    assign in_frame = (state_q == WAIT_B) || (state_q == WAIT_OP);

    alu_uart_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (~in_frame | i_rx_done),
        .i_enable (in_frame & ~i_rx_done),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                WAIT_A: begin
                    if (i_rx_done) begin
                        a_q     <= i_rx_data[NB_DATA-1:0];
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        b_q     <= i_rx_data[NB_DATA-1:0];
                        state_q <= WAIT_OP;
                    end else if (expired) begin
                        state_q <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        op_q    <= i_rx_data[NB_OP-1:0];
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else if (expired) begin
                        state_q <= WAIT_A;
                    end
                end
                // Pulse is raised here so it is visible during SEND.
                CALC: begin
                    tx_data_q  <= NB_UART_DATA'(i_alu_result);
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_data_A = a_q;
    assign o_alu_data_B = b_q;
    assign o_alu_op     = op_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: directed frames with literal results plus a
// randomized run checked every cycle against a frame-level model.
module tb_alu_uart_if;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res;
    logic [7:0] o_a;
    logic [7:0] o_b;
    logic [5:0] o_op;
    logic [7:0] o_tx;
    logic       o_start;
    logic       o_bsy;

    int n_chk = 0;
    int n_fail = 0;
    int starts = 0;
    bit chk_en = 1'b0;

    alu_uart_if #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_tx_done   (tx_done),
        .i_alu_result(alu_res),
        .o_alu_data_A(o_a),
        .o_alu_data_B(o_b),
        .o_alu_op    (o_op),
        .o_tx_data   (o_tx),
        .o_tx_start  (o_start),
        .o_busy      (o_bsy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = alu_f(o_a, o_b, o_op);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Frame-level model: byte count, idle count, post-opcode phase.
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_busy;
    int         m_nb, m_idle, m_phase;

    always @(posedge clk) begin
        if (rst) begin
            m_a <= 0; m_b <= 0; m_op <= 0; m_tx <= 0;
            m_start <= 0; m_busy <= 0;
            m_nb <= 0; m_idle <= 0; m_phase <= 0;
        end else begin
            m_start <= 0;
            case (m_phase)
                0: begin
                    if (rx_done) begin
                        m_idle <= 0;
                        if (m_nb == 0) m_a <= rx_data;
                        else if (m_nb == 1) m_b <= rx_data;
                        else m_op <= rx_data[5:0];
                        if (m_nb == 2) begin
                            m_nb <= 0;
                            m_phase <= 1;
                            m_busy <= 1;
                        end else begin
                            m_nb <= m_nb + 1;
                        end
                    end else if (m_nb != 0) begin
                        if (m_idle == TO - 1) begin
                            m_nb <= 0;
                            m_idle <= 0;
                        end else begin
                            m_idle <= m_idle + 1;
                        end
                    end
                end
                1: begin
                    m_tx <= alu_f(m_a, m_b, m_op);
                    m_start <= 1;
                    m_phase <= 2;
                end
                2: m_phase <= 3;
                default: begin
                    if (tx_done) begin
                        m_phase <= 0;
                        m_busy <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_A", o_a, m_a);
            check("cyc_B", o_b, m_b);
            check("cyc_op", o_op, m_op);
            check("cyc_tx_data", o_tx, m_tx);
            check("cyc_tx_start", o_start, m_start);
            check("cyc_busy", o_bsy, m_busy);
        end
    end

    always @(posedge clk) if (o_start) starts <= starts + 1;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check("calc_no_start", o_start, 1'b0);
        check("calc_busy", o_bsy, 1'b1);
        @(negedge clk);
        check("start_at_n2", o_start, 1'b1);
        check("result", o_tx, exp);
        @(negedge clk);
        check("start_one_cycle", o_start, 1'b0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_after_tx", o_bsy, 1'b0);
    endtask

    task automatic wait_wait_tx();
        for (int i = 0; i < 10 && m_phase != 3; i++) @(negedge clk);
        check("reach_wait_tx", 32'(m_phase == 3), 1);
    endtask

    int s0;
    logic [5:0] ops[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                           6'h03, 6'h02, 6'h27, 6'h11};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_A", o_a, 0);
        check("rst_B", o_b, 0);
        check("rst_op", o_op, 0);
        check("rst_tx", o_tx, 0);
        check("rst_start", o_start, 0);
        check("rst_busy", o_bsy, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_frame(8'h05, 8'h03, 8'h20, 8'h08);
        check("add_A", o_a, 8'h05);
        check("add_B", o_b, 8'h03);
        check("add_op", o_op, 6'h20);

        do_frame(8'h10, 8'h11, 8'hE2, 8'hFF);
        check("trunc_op", o_op, 6'h22);

        send_byte(8'h07);
        repeat (TO) @(negedge clk);
        check("timeout_keep_A", o_a, 8'h07);
        do_frame(8'h01, 8'h02, 8'h20, 8'h03);

        send_byte(8'h07);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h09);
        check("expiry_byte_B", o_b, 8'h09);
        send_byte(8'h20);
        @(negedge clk);
        check("expiry_result", o_tx, 8'h10);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;

        send_byte(8'h30);
        send_byte(8'h40);
        send_byte(8'h20);
        wait_wait_tx();
        rx_data = 8'hAA;
        rx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        check("discard_A", o_a, 8'h30);
        check("discard_B", o_b, 8'h40);
        check("discard_busy", o_bsy, 0);
        do_frame(8'h04, 8'h04, 8'h24, 8'h04);

        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstop_A", o_a, 0);
        check("rstop_B", o_b, 0);
        send_byte(8'h0F);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstsend_start", o_start, 0);
        check("rstsend_tx", o_tx, 0);
        check("rstsend_op", o_op, 0);
        check("rstsend_busy", o_bsy, 0);
        do_frame(8'h0C, 8'h0A, 8'h26, 8'h06);

        s0 = starts;
        do_frame(8'h80, 8'h02, 8'h03, 8'hE0);
        do_frame(8'h80, 8'h02, 8'h02, 8'h20);
        do_frame(8'h0F, 8'hF0, 8'h27, 8'h00);
        check("b2b_starts", starts - s0, 3);

        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 3; k++) begin
                int gap;
                gap = ($urandom_range(0, 11) == 0) ? TO + 2
                                                   : $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                if (k == 2) send_byte({2'($urandom), ops[$urandom_range(0, 8)]});
                else send_byte(8'($urandom));
            end
            if (m_busy) begin
                wait_wait_tx();
                repeat ($urandom_range(0, 3)) begin
                    rx_done = ($urandom_range(0, 2) == 0);
                    rx_data = 8'($urandom);
                    @(negedge clk);
                end
                tx_done = 1'b1;
                rx_done = $urandom_range(0, 1) == 1;
                @(negedge clk);
                tx_done = 1'b0;
                rx_done = 1'b0;
            end
        end
        repeat (TO + 2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
